// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART byte receiver: finds SYNC, takes a LEN-prefixed payload,
// verifies the XOR checksum, then replays the buffered payload on a valid/ready stream.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            IW        = $clog2(MAX_LEN + 1);
  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [15:0]   IDLE_LAST = 16'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    LEN_MAX   = 8'(MAX_LEN);

  // state   | meaning: HUNT wait for SYNC | LEN take length | PAYLOAD buffer bytes
  //         |          CHECK compare checksum | SEND replay buffer downstream
  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_SEND    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [15:0]   idle_q, idle_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          buf_we;
  logic [7:0]    pbuf_q [MAX_LEN];

  logic          in_frame;
  logic          timeout;
  logic          xfer;
  logic [IW-1:0] len_last;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  // A byte in the expiry cycle wins over the timeout.
  assign timeout  = in_frame && !rx_data_valid && (idle_q == IDLE_LAST);
  assign xfer     = (state_q == S_SEND) && out_ready;
  assign len_last = len_q - IDX_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      chk_q    <= '0;
      idle_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      len_q    <= len_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      chk_q    <= chk_d;
      idle_q   <= idle_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      pbuf_q[wr_idx_q[AW-1:0]] <= rx_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    chk_d    = chk_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    buf_we   = 1'b0;

    if (!in_frame || rx_data_valid || timeout) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 16'd1;
    end

    case (state_q)
      S_HUNT: begin
        if (rx_data_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_data_valid) begin
          if ((rx_data == 8'd0) || (rx_data > LEN_MAX)) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            len_d    = IW'(rx_data);
            chk_d    = rx_data;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (rx_data_valid) begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ rx_data;
          wr_idx_d = wr_idx_q + IDX_ONE;
          if (wr_idx_q == len_last) begin
            state_d = S_CHECK;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HUNT;
        end
      end
      S_CHECK: begin
        if (rx_data_valid) begin
          if (rx_data == chk_q) begin
            rd_idx_d = '0;
            state_d  = S_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HUNT;
        end
      end
      S_SEND: begin
        // Bytes arriving while replaying are dropped; the buffer is left intact.
        if (rx_data_valid) begin
          ovr_d = 1'b1;
        end
        if (xfer) begin
          if (rd_idx_q == len_last) begin
            ok_d    = 1'b1;
            state_d = S_HUNT;
          end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    if (state_q == S_SEND) begin
      out_valid = 1'b1;
      out_data  = pbuf_q[rd_idx_q[AW-1:0]];
      out_last  = (rd_idx_q == len_last);
    end
  end

  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus randomized frame
// streams compared against a frame-level reference parser.
module tb_uart_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TC   = 1100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;

  int n_vec  = 0;
  int n_miss = 0;
  int n_ok   = 0;
  int n_err  = 0;
  int n_ovr  = 0;
  bit rand_ready = 1'b0;

  logic [7:0] got_data [$];
  bit         got_last [$];
  logic [7:0] stream   [$];
  logic [7:0] exp_data [$];
  bit         exp_last [$];
  int         exp_ok;
  int         exp_err;
  logic [7:0] pay3 [3] = '{8'h11, 8'h22, 8'h33};

  uart_frame_parser #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLKS(TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
      if (overrun)   n_ovr++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_good3();
    drive_byte(SYNC); drive_byte(8'h03);
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
    drive_byte(8'h03);
  endtask

  task automatic wait_idle(input int budget);
    int cnt = 0;
    while (out_valid && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  task automatic check_got3(input string name, input int base);
    n_vec++;
    if (got_data.size() - base != 3) begin
      n_miss++;
      $display("FAIL %s count got %0d want 3", name, got_data.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_data[base+k] !== pay3[k] || got_last[base+k] !== (k == 2)) begin
          n_miss++;
          $display("FAIL %s byte%0d got %h/%0b want %h/%0b", name, k,
                   got_data[base+k], got_last[base+k], pay3[k], (k == 2));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({out_valid, out_data, out_last, frame_ok, frame_err, overrun} !== 13'd0) begin
      n_miss++;
      $display("FAIL reset_hold got v=%0b d=%h l=%0b ok=%0b err=%0b ovr=%0b want all 0",
               out_valid, out_data, out_last, frame_ok, frame_err, overrun);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({out_valid, out_data, out_last, frame_ok, frame_err, overrun} !== 13'd0) begin
      n_miss++;
      $display("FAIL reset_release got v=%0b d=%h l=%0b want all 0", out_valid, out_data, out_last);
    end
  endtask

  task automatic test_good_frame();
    int ok0 = n_ok;
    int err0 = n_err;
    out_ready = 1'b1;
    send_good3();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== pay3[k] || out_last !== (k == 2)) begin
        n_miss++;
        $display("FAIL good_out%0d got v=%0b d=%h l=%0b want 1 %h %0b",
                 k, out_valid, out_data, out_last, pay3[k], (k == 2));
      end
      tick();
    end
    n_vec++;
    if (frame_ok !== 1'b1 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL good_ok_pulse got ok=%0b v=%0b want ok=1 v=0", frame_ok, out_valid);
    end
    tick();
    tick();
    n_vec++;
    if (n_ok - ok0 != 1 || n_err - err0 != 0) begin
      n_miss++;
      $display("FAIL good_counts got ok=%0d err=%0d want 1 0", n_ok - ok0, n_err - err0);
    end
  endtask

  task automatic test_bad_chk();
    int base;
    int ok0;
    out_ready = 1'b1;
    drive_byte(SYNC); drive_byte(8'h03);
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
    drive_byte(8'h04);
    n_vec++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL badchk_err got err=%0b v=%0b want err=1 v=0", frame_err, out_valid);
    end
    tick();
    n_vec++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL badchk_pulse_width got err=%0b v=%0b want 0 0", frame_err, out_valid);
    end
    base = got_data.size();
    ok0 = n_ok;
    send_good3();
    wait_idle(50);
    tick();
    check_got3("badchk_next", base);
    n_vec++;
    if (n_ok - ok0 != 1) begin
      n_miss++;
      $display("FAIL badchk_next_ok got %0d want 1", n_ok - ok0);
    end
  endtask

  task automatic test_bad_len();
    int err0 = n_err;
    drive_byte(8'h00); drive_byte(8'hFF); drive_byte(8'h5A);
    tick();
    n_vec++;
    if (n_err != err0 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL garbage_silent got err=%0d v=%0b want 0 0", n_err - err0, out_valid);
    end
    drive_byte(SYNC); drive_byte(8'h00);
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_miss++;
      $display("FAIL len_zero got err=%0b want 1", frame_err);
    end
    drive_byte(SYNC); drive_byte(8'(MAXL + 1));
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_miss++;
      $display("FAIL len_over got err=%0b want 1", frame_err);
    end
    tick();
    tick();
    n_vec++;
    if (n_err - err0 != 2) begin
      n_miss++;
      $display("FAIL len_err_count got %0d want 2", n_err - err0);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int ok0 = n_ok;
    int cnt = 0;
    out_ready = 1'b0;
    send_good3();
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_hold%0d got v=%0b d=%h l=%0b want 1 11 0", k, out_valid, out_data, out_last);
      end
      tick();
    end
    base = got_data.size();
    while (n_ok == ok0 && cnt < 40) begin
      out_ready = ~out_ready;
      tick();
      cnt++;
    end
    out_ready = 1'b1;
    tick();
    check_got3("bp_order", base);
    n_vec++;
    if (n_ok - ok0 != 1) begin
      n_miss++;
      $display("FAIL bp_ok got %0d want 1", n_ok - ok0);
    end
  endtask

  task automatic test_timeout();
    int err0;
    int ok0;
    int base;
    out_ready = 1'b1;
    drive_byte(SYNC); drive_byte(8'h03); drive_byte(8'h11);
    repeat (TC - 1) tick();
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_early got err=%0b want 0", frame_err);
    end
    tick();
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_miss++;
      $display("FAIL timeout_fire got err=%0b want 1", frame_err);
    end
    tick();
    err0 = n_err;
    ok0 = n_ok;
    base = got_data.size();
    drive_byte(SYNC); drive_byte(8'h03); drive_byte(8'h11);
    repeat (TC - 2) tick();
    drive_byte(8'h22);
    repeat (TC - 2) tick();
    drive_byte(8'h33);
    drive_byte(8'h03);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_miss++;
      $display("FAIL timeout_gap_accept got v=%0b d=%h want 1 11", out_valid, out_data);
    end
    wait_idle(50);
    tick();
    check_got3("timeout_gap_data", base);
    n_vec++;
    if (n_err != err0 || n_ok - ok0 != 1) begin
      n_miss++;
      $display("FAIL timeout_gap_counts got err=%0d ok=%0d want 0 1", n_err - err0, n_ok - ok0);
    end
  endtask

  task automatic test_overrun_reset();
    int base;
    int ok0 = n_ok;
    int ovr0 = n_ovr;
    int err0;
    out_ready = 1'b0;
    send_good3();
    tick();
    drive_byte(8'h55);
    n_vec++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_miss++;
      $display("FAIL ovr_pulse got ovr=%0b v=%0b d=%h want 1 1 11", overrun, out_valid, out_data);
    end
    tick();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_miss++;
      $display("FAIL ovr_width got %0b want 0", overrun);
    end
    drive_byte(SYNC);
    base = got_data.size();
    out_ready = 1'b1;
    wait_idle(50);
    tick();
    check_got3("ovr_payload", base);
    n_vec++;
    if (n_ovr - ovr0 != 2 || n_ok - ok0 != 1) begin
      n_miss++;
      $display("FAIL ovr_counts got ovr=%0d ok=%0d want 2 1", n_ovr - ovr0, n_ok - ok0);
    end
    out_ready = 1'b0;
    ok0 = n_ok;
    err0 = n_err;
    send_good3();
    tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, frame_ok, frame_err, overrun} !== 4'd0) begin
      n_miss++;
      $display("FAIL rst_send got v=%0b ok=%0b err=%0b ovr=%0b want 0", out_valid, frame_ok, frame_err, overrun);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    drive_byte(8'h03); drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33); drive_byte(8'h03);
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || n_err != err0 || n_ok != ok0) begin
      n_miss++;
      $display("FAIL rst_hunt got v=%0b err=%0d ok=%0d want 0 0 0", out_valid, n_err - err0, n_ok - ok0);
    end
    base = got_data.size();
    send_good3();
    wait_idle(50);
    tick();
    check_got3("rst_next", base);
  endtask

  task automatic run_model();
    int i = 0;
    int len;
    logic [7:0] c;
    exp_data.delete();
    exp_last.delete();
    exp_ok = 0;
    exp_err = 0;
    while (i < stream.size()) begin
      if (stream[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= stream.size()) break;
      len = int'(stream[i+1]);
      i += 2;
      if (len == 0 || len > MAXL) begin
        exp_err++;
        continue;
      end
      if (i + len >= stream.size()) break;
      c = 8'(len);
      for (int k = 0; k < len; k++) c ^= stream[i+k];
      if (stream[i+len] == c) begin
        for (int k = 0; k < len; k++) begin
          exp_data.push_back(stream[i+k]);
          exp_last.push_back(k == len - 1);
        end
        exp_ok++;
      end else begin
        exp_err++;
      end
      i += len + 1;
    end
  endtask

  task automatic send_rand(input logic [7:0] b);
    stream.push_back(b);
    drive_byte(b);
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic test_random();
    int base = got_data.size();
    int ok0 = n_ok;
    int err0 = n_err;
    int ovr0 = n_ovr;
    int kind;
    int len;
    logic [7:0] b;
    logic [7:0] c;
    stream.delete();
    rand_ready = 1'b1;
    for (int u = 0; u < 40; u++) begin
      kind = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        send_rand(b);
      end
      send_rand(SYNC);
      if (kind == 0) begin
        if ($urandom_range(0, 1) == 0) send_rand(8'h00);
        else send_rand(8'($urandom_range(MAXL + 1, 255)));
      end else begin
        len = $urandom_range(1, MAXL);
        c = 8'(len);
        send_rand(8'(len));
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          c ^= b;
          send_rand(b);
        end
        if (kind == 1) c ^= 8'($urandom_range(1, 255));
        send_rand(c);
      end
      wait_idle(2000);
      n_vec++;
      if (out_valid) begin
        n_miss++;
        $display("FAIL rand_drain unit %0d still valid after budget", u);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    run_model();
    n_vec++;
    if (got_data.size() - base != exp_data.size()) begin
      n_miss++;
      $display("FAIL rand_len got %0d want %0d", got_data.size() - base, exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && base + k < got_data.size(); k++) begin
      n_vec++;
      if (got_data[base+k] !== exp_data[k] || got_last[base+k] !== exp_last[k]) begin
        n_miss++;
        $display("FAIL rand_byte%0d got %h/%0b want %h/%0b", k,
                 got_data[base+k], got_last[base+k], exp_data[k], exp_last[k]);
      end
    end
    n_vec++;
    if (n_ok - ok0 != exp_ok || n_err - err0 != exp_err || n_ovr != ovr0) begin
      n_miss++;
      $display("FAIL rand_counts got ok=%0d err=%0d ovr=%0d want %0d %0d 0",
               n_ok - ok0, n_err - err0, n_ovr - ovr0, exp_ok, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_backpressure();
    test_timeout();
    test_overrun_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
